// File: rtl/frame_streamer_pkg.sv
// Shared definitions for the frame streamer: image geometry, pixel layout,
// FIFO word layout and the scan FSM state type.
package frame_streamer_pkg;

  localparam int unsigned WIDTH      = 64;
  localparam int unsigned HEIGHT     = 64;
  localparam int unsigned PIX_W      = 24;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned CK_W  = 20;

  // G channel position inside a pixel
  localparam int unsigned G_LSB = 8;
  localparam int unsigned G_MSB = 15;

  // FIFO word: {pixel, sof, eol, eof}
  localparam int unsigned WORD_W  = PIX_W + 3;
  localparam int unsigned EOF_BIT = 0;
  localparam int unsigned EOL_BIT = 1;
  localparam int unsigned SOF_BIT = 2;
  localparam int unsigned PIX_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [PIX_W-1:0] pix,
    input logic             sof,
    input logic             eol,
    input logic             eof
  );
    return {pix, sof, eol, eof};
  endfunction

endpackage

// File: rtl/frame_streamer_stream_fifo.sv
// stream_fifo: small synchronous FIFO for the pixel stream.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_data    write request and word
//   i_pop             read request (ignored when empty)
//   o_data            word at the head, read directly from storage registers
//   o_full, o_empty   occupancy flags
// A push is accepted while full if a pop happens in the same cycle.
module stream_fifo #(
  parameter int unsigned W     = 27,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_do_pop) r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: after a start pulse, raster-scans the image through the
// row/col read port and streams every pixel out on valid/ready with sof/eol/eof
// markers, publishing a G-channel checksum of the frame when it completes.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              one-cycle frame request (ignored unless idle)
//   row, col           registered image read address
//   in_pix             pixel at (row,col), combinational
//   out_data/out_valid/out_ready  output stream
//   out_sof/out_eol/out_eof       beat markers
//   busy               frame in progress (scan or drain)
//   frame_done         one-cycle pulse after the final beat leaves
//   checksum           G-channel sum of the last completed frame, mod 2^20
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             frame_done,
  output logic [CK_W-1:0]  checksum
);

  state_t            r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [CK_W-1:0]   r_acc;
  logic [CK_W-1:0]   r_checksum;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_last_col;
  logic              w_last_row;
  logic              w_sof;
  logic              w_eof;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_head;

  assign w_last_col = (r_col == COL_W'(WIDTH - 1));
  assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));
  assign w_sof      = (r_row == '0) && (r_col == '0);
  assign w_eof      = w_last_row && w_last_col;
  assign w_word     = pack_word(in_pix, w_sof, w_last_col, w_eof);

  assign w_pop  = !w_empty && out_ready;
  // Pushing into a full FIFO is allowed when the head leaves in the same
  // cycle, which keeps the stream at one pixel per cycle.
  assign w_push = (r_state == ST_SCAN) && (!w_full || w_pop);

  stream_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_acc        <= '0;
      r_checksum   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_push) begin
            r_acc <= r_acc + CK_W'(in_pix[G_MSB:G_LSB]);
            if (w_eof) begin
              r_state <= ST_DRAIN;
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_checksum   <= r_acc;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign row        = r_row;
  assign col        = r_col;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign checksum   = r_checksum;

  // Data and markers are forced low whenever no beat is presented.
  assign out_valid = !w_empty;
  assign out_data  = out_valid ? w_head[PIX_LSB +: PIX_W] : '0;
  assign out_sof   = out_valid && w_head[SOF_BIT];
  assign out_eol   = out_valid && w_head[EOL_BIT];
  assign out_eof   = out_valid && w_head[EOF_BIT];

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

  localparam int IW = 64;
  localparam int IH = 64;
  localparam int NBEATS = IW * IH;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] in_pix;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic        busy;
  logic        frame_done;
  logic [19:0] checksum;

  frame_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .row        (row),
    .col        (col),
    .in_pix     (in_pix),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  // Image memory behind the combinational read port
  logic [23:0] img [IH][IW];
  assign in_pix = img[row][col];

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  beat_t       exp_q[$];
  logic [19:0] ck_q[$];

  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned beat_idx = 0;
  int unsigned done_cnt = 0;
  int unsigned first_beat_cyc = 0;
  int unsigned last_beat_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned start_cyc = 0;
  bit          ready_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink back-pressure
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold while stalled
  initial begin : monitor
    beat_t prev;
    beat_t cur;
    beat_t e;
    bit    stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      cur = {out_data, out_sof, out_eol, out_eof};
      if (stall) check($sformatf("hold beat %0d", beat_idx), {out_valid, cur}, {1'b1, prev});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: got %0h expected no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat %0d", beat_idx), cur, e);
        end
        if (beat_idx == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beat_idx++;
      end
      stall = out_valid && !out_ready;
      prev  = cur;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (ck_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_frame_done: got 1 expected 0");
        end else begin
          check("checksum", checksum, ck_q.pop_front());
        end
      end
    end
  end

  task automatic fill_image(input int mode);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        case (mode)
          0:       img[r][c] = {8'(r), 8'(r + c), 8'(c)};
          1:       img[r][c] = 24'($urandom);
          default: img[r][c] = {8'($urandom), 8'hFF, 8'($urandom)};
        endcase
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reference model: row-major beats with markers, G sum mod 2^20
  task automatic issue_frame();
    beat_t       b;
    logic [19:0] ck;
    ck = '0;
    beat_idx = 0;
    for (int k = 0; k < NBEATS; k++) begin
      b.d   = img[k / IW][k % IW];
      b.sof = (k == 0);
      b.eol = ((k % IW) == IW - 1);
      b.eof = (k == NBEATS - 1);
      exp_q.push_back(b);
      ck = ck + 20'(b.d[15:8]);
    end
    ck_q.push_back(ck);
    pulse_start();
  endtask

  task automatic wait_done(input int unsigned target, input string name);
    int unsigned n;
    n = 0;
    while (done_cnt < target && n < 12000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done_count"}, done_cnt, target);
  endtask

  task automatic wait_beat(input int unsigned b);
    int unsigned n;
    n = 0;
    while (beat_idx < b && n < 12000) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("reach_beat_%0d", b), beat_idx >= b, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {row, col, out_valid, out_data, out_sof, out_eol, out_eof,
                 busy, frame_done, checksum}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill_image(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Pattern image, sink always ready: latency and gap-free stream
    fill_image(0);
    issue_frame();
    wait_done(1, "t1");
    check("t1_first_valid_latency", first_beat_cyc - start_cyc, 2);
    check("t1_no_gaps", last_beat_cyc - first_beat_cyc, NBEATS - 1);
    check("t1_done_latency", (done_cyc - start_cyc >= 4098) && (done_cyc - start_cyc <= 4099), 1);
    check("t1_checksum_value", checksum, 20'd258048);
    check("t1_beats", beat_idx, NBEATS);
    @(posedge clk);
    #1;
    check("t1_idle_busy", busy, 0);

    // Random image, random back-pressure
    fill_image(1);
    ready_rand = 1'b1;
    issue_frame();
    wait_done(2, "t2");
    check("t2_beats", beat_idx, NBEATS);
    ready_rand = 1'b0;

    // Second start mid-frame is ignored
    fill_image(0);
    issue_frame();
    wait_beat(1000);
    pulse_start();
    check("t4_busy_mid", busy, 1);
    wait_done(3, "t4");
    repeat (20) @(posedge clk);
    check("t4_single_done", done_cnt, 3);
    check("t4_beats", beat_idx, NBEATS);
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset mid-frame abandons it, next frame is complete
    fill_image(1);
    ready_rand = 1'b1;
    issue_frame();
    wait_beat(2000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_reset_mid_frame");
    exp_q.delete();
    ck_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("t5_no_partial_done", done_cnt, 3);
    issue_frame();
    wait_done(4, "t5");
    check("t5_beats", beat_idx, NBEATS);
    ready_rand = 1'b0;

    // All G=255, back-to-back frames
    fill_image(2);
    issue_frame();
    wait_done(5, "t6a");
    check("t6a_checksum_value", checksum, 20'd1044480);
    issue_frame();
    wait_done(6, "t6b");
    check("t6b_checksum_value", checksum, 20'd1044480);
    check("t6b_beats", beat_idx, NBEATS);

    repeat (10) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_cnt, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
